// File: rtl/uart_tx_cfg.sv
// UART transmitter with a small transmit FIFO and per-frame configuration
// (parity enable/type, one or two stop bits, clk cycles per bit).
//
// state  | meaning
// IDLE   | line high, waiting for a FIFO entry
// START  | start bit (low) for one bit period
// DATA   | data bits, LSB first, one bit period each
// PARITY | optional parity bit
// STOP   | stop bit(s), line high
module uart_tx_cfg #(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          Data_Valid,
    input  logic [DATA_WIDTH-1:0]         P_Data,
    input  logic                          par_en,
    input  logic                          PAR_TYP,
    input  logic                          stop2,
    input  logic [PRESCALE_WIDTH-1:0]     prescale,
    output logic                          ready,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          TX_OUT,
    output logic                          busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0]             DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0]             LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_WIDTH-1:0] ONE_P    = PRESCALE_WIDTH'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                    state;
    logic [DATA_WIDTH-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             rd_ptr;
    logic [DATA_WIDTH-1:0]     shift_reg;
    logic [BW-1:0]             bit_cnt;
    logic [PRESCALE_WIDTH-1:0] tick_cnt;
    logic [PRESCALE_WIDTH-1:0] period_m1;
    logic [PRESCALE_WIDTH-1:0] prescale_eff;
    logic                      par_en_q;
    logic                      stop2_q;
    logic                      parity_q;
    logic                      stop_left;
    logic                      wr_en;
    logic                      pop;
    logic                      bit_end;

    assign ready        = (fifo_count < DEPTH_C);
    assign wr_en        = Data_Valid && ready;
    assign bit_end      = (tick_cnt == '0);
    assign prescale_eff = (prescale == '0) ? ONE_P : prescale;
    // A frame starts from IDLE, or back-to-back at the end of the last stop bit.
    assign pop = (fifo_count != '0) &&
                 ((state == IDLE) || ((state == STOP) && bit_end && !stop_left));

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            overflow <= Data_Valid && !ready;
            if (wr_en) begin
                mem[wr_ptr] <= P_Data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            TX_OUT    <= 1'b1;
            busy      <= 1'b0;
            tick_cnt  <= '0;
            period_m1 <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            parity_q  <= 1'b0;
            stop_left <= 1'b0;
        end else if (pop) begin
            // Frame configuration is captured here and held for the whole frame.
            state     <= START;
            TX_OUT    <= 1'b0;
            busy      <= 1'b1;
            shift_reg <= mem[rd_ptr];
            parity_q  <= (^mem[rd_ptr]) ^ PAR_TYP;
            par_en_q  <= par_en;
            stop2_q   <= stop2;
            period_m1 <= prescale_eff - ONE_P;
            tick_cnt  <= prescale_eff - ONE_P;
            bit_cnt   <= '0;
            stop_left <= 1'b0;
        end else if ((state != IDLE) && !bit_end) begin
            tick_cnt <= tick_cnt - ONE_P;
        end else begin
            tick_cnt <= period_m1;
            case (state)
                IDLE: begin
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                end
                START: begin
                    state   <= DATA;
                    TX_OUT  <= shift_reg[0];
                    bit_cnt <= '0;
                end
                DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        if (par_en_q) begin
                            state  <= PARITY;
                            TX_OUT <= parity_q;
                        end else begin
                            state     <= STOP;
                            TX_OUT    <= 1'b1;
                            stop_left <= stop2_q;
                        end
                    end else begin
                        bit_cnt   <= bit_cnt + BW'(1);
                        shift_reg <= shift_reg >> 1;
                        TX_OUT    <= shift_reg[1];
                    end
                end
                PARITY: begin
                    state     <= STOP;
                    TX_OUT    <= 1'b1;
                    stop_left <= stop2_q;
                end
                STOP: begin
                    if (stop_left) begin
                        stop_left <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: a queue-based frame model checked every cycle,
// plus hand-computed waveform expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_uart_tx_cfg;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int PW    = 16;
    localparam int LOGN  = 8192;

    logic          clk = 1'b0;
    logic          reset;
    logic          Data_Valid;
    logic [DW-1:0] P_Data;
    logic          par_en;
    logic          PAR_TYP;
    logic          stop2;
    logic [PW-1:0] prescale;
    logic          ready;
    logic          overflow;
    logic [2:0]    fifo_count;
    logic          TX_OUT;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int base   = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PRESCALE_WIDTH(PW)) dut (
        .clk(clk), .reset(reset), .Data_Valid(Data_Valid), .P_Data(P_Data),
        .par_en(par_en), .PAR_TYP(PAR_TYP), .stop2(stop2), .prescale(prescale),
        .ready(ready), .overflow(overflow), .fifo_count(fifo_count),
        .TX_OUT(TX_OUT), .busy(busy)
    );

    // Model: FIFO of words plus a queue of line levels for the frame in flight.
    logic [DW-1:0] fq[$];
    bit            lq[$];
    bit            m_valid = 1'b0;
    bit            m_tx    = 1'b1;
    bit            m_busy  = 1'b0;
    bit            m_ovf   = 1'b0;

    function automatic void add_bit(bit v, int n);
        repeat (n) lq.push_back(v);
    endfunction

    always @(posedge clk) begin : model
        int            pre;
        int            p;
        bit            acc;
        logic [DW-1:0] w;
        if (reset) begin
            fq.delete();
            lq.delete();
            m_tx    = 1'b1;
            m_busy  = 1'b0;
            m_ovf   = 1'b0;
            m_valid = 1'b1;
        end else begin
            pre   = fq.size();
            acc   = Data_Valid && (pre < DEPTH);
            m_ovf = Data_Valid && !acc;
            if (lq.size() == 0 && pre > 0) begin
                w = fq.pop_front();
                p = (prescale == 0) ? 1 : int'(prescale);
                add_bit(1'b0, p);
                for (int b = 0; b < DW; b++) add_bit(w[b], p);
                if (par_en) add_bit((^w) ^ PAR_TYP, p);
                add_bit(1'b1, p);
                if (stop2) add_bit(1'b1, p);
            end
            if (lq.size() > 0) begin
                m_tx   = lq.pop_front();
                m_busy = 1'b1;
            end else begin
                m_tx   = 1'b1;
                m_busy = 1'b0;
            end
            if (acc) fq.push_back(P_Data);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (TX_OUT !== m_tx || busy !== m_busy || overflow !== m_ovf ||
                ready !== (fq.size() < DEPTH) || fifo_count !== fq.size()) begin
                errors++;
                $display("FAIL model cyc=%0d: got tx=%b busy=%b rdy=%b ovf=%b cnt=%0d expected tx=%b busy=%b rdy=%b ovf=%b cnt=%0d",
                         cyc, TX_OUT, busy, ready, overflow, fifo_count,
                         m_tx, m_busy, fq.size() < DEPTH, m_ovf, fq.size());
            end
        end
    end

    bit log_tx  [LOGN];
    bit log_busy[LOGN];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (cyc < LOGN) begin
            log_tx[cyc]   = TX_OUT;
            log_busy[cyc] = busy;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int busy_count(int from, int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += log_busy[from + i];
        return s;
    endfunction

    function automatic int ones_count(int from, int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += log_tx[from + i];
        return s;
    endfunction

    task automatic send_one(input logic [DW-1:0] d);
        Data_Valid = 1'b1;
        P_Data     = d;
        @(negedge clk);
        Data_Valid = 1'b0;
        @(negedge clk);
        base = cyc;
    endtask

    int a5_wave[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int w96_wave[10] = '{0, 0, 1, 1, 0, 1, 0, 0, 1, 1};
    logic [DW-1:0] ovf_words[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    initial begin
        int mism;
        logic [DW-1:0] word;
        reset = 1'b1; Data_Valid = 1'b0; P_Data = '0; par_en = 1'b0;
        PAR_TYP = 1'b0; stop2 = 1'b0; prescale = 16'd4;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_tx", TX_OUT, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", ready, 1);
        chk("rst_ovf", overflow, 0);
        chk("rst_count", fifo_count, 0);

        // 0xA5, 8N1, 4 cycles per bit
        Data_Valid = 1'b1; P_Data = 8'hA5;
        @(negedge clk);
        Data_Valid = 1'b0;
        chk("a5_count_after_write", fifo_count, 1);
        chk("a5_tx_before_start", TX_OUT, 1);
        @(negedge clk);
        base = cyc;
        chk("a5_start_low", TX_OUT, 0);
        repeat (50) @(negedge clk);
        mism = 0;
        for (int j = 0; j < 40; j++) if (log_tx[base + j] != a5_wave[j / 4]) mism++;
        chk("a5_waveform_mismatches", mism, 0);
        chk("a5_busy_cycles", busy_count(base, 50), 40);

        // parity even then odd
        par_en = 1'b1; PAR_TYP = 1'b0;
        send_one(8'hA5);
        repeat (50) @(negedge clk);
        chk("par_even_bit", log_tx[base + 38], 0);
        chk("par_even_stop", log_tx[base + 42], 1);
        chk("par_even_len", busy_count(base, 50), 44);
        PAR_TYP = 1'b1;
        send_one(8'hA5);
        repeat (50) @(negedge clk);
        chk("par_odd_bit", log_tx[base + 38], 1);
        chk("par_odd_len", busy_count(base, 50), 44);

        // two stop bits, two words back to back
        par_en = 1'b0; PAR_TYP = 1'b0; stop2 = 1'b1;
        Data_Valid = 1'b1; P_Data = 8'h3C;
        @(negedge clk);
        P_Data = 8'hC3;
        @(negedge clk);
        Data_Valid = 1'b0;
        base = cyc;
        chk("s2_start_low", TX_OUT, 0);
        repeat (100) @(negedge clk);
        chk("s2_last_data", log_tx[base + 35], 0);
        chk("s2_stop_high", ones_count(base + 36, 8), 8);
        chk("s2_second_start", log_tx[base + 44], 0);
        chk("s2_second_bit0", log_tx[base + 48], 1);
        chk("s2_busy_continuous", busy_count(base, 100), 88);

        // FIFO fill and overflow
        stop2 = 1'b0;
        Data_Valid = 1'b1; P_Data = 8'h11;
        @(negedge clk);
        P_Data = 8'h22;
        @(negedge clk);
        base = cyc;
        P_Data = 8'h33;
        @(negedge clk);
        P_Data = 8'h44;
        @(negedge clk);
        P_Data = 8'h55;
        @(negedge clk);
        chk("full_ready", ready, 0);
        chk("full_count", fifo_count, 4);
        P_Data = 8'h66;
        @(negedge clk);
        chk("ovf_pulse", overflow, 1);
        chk("ovf_count", fifo_count, 4);
        Data_Valid = 1'b0;
        @(negedge clk);
        chk("ovf_one_cycle", overflow, 0);
        repeat (215) @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            for (int b = 0; b < DW; b++) word[b] = log_tx[base + 40 * j + 4 * (1 + b) + 2];
            chk($sformatf("order_word%0d", j), word, ovf_words[j]);
        end
        chk("order_busy", busy_count(base, 210), 200);

        // reset mid-DATA with two words queued; write on the reset edge ignored
        Data_Valid = 1'b1; P_Data = 8'h5A;
        @(negedge clk);
        P_Data = 8'h6B;
        @(negedge clk);
        P_Data = 8'h7C;
        @(negedge clk);
        Data_Valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_busy", busy, 1);
        chk("mid_count", fifo_count, 2);
        reset = 1'b1; Data_Valid = 1'b1; P_Data = 8'h99;
        @(negedge clk);
        reset = 1'b0; Data_Valid = 1'b0;
        chk("abort_tx", TX_OUT, 1);
        chk("abort_busy", busy, 0);
        chk("abort_count", fifo_count, 0);
        chk("abort_ready", ready, 1);
        base = cyc;
        repeat (60) @(negedge clk);
        chk("abort_no_frames", busy_count(base, 60), 0);
        chk("abort_line_high", ones_count(base, 60), 60);

        // prescale 0 behaves as 1
        prescale = 16'd0;
        send_one(8'h96);
        repeat (20) @(negedge clk);
        mism = 0;
        for (int j = 0; j < 10; j++) if (log_tx[base + j] != w96_wave[j]) mism++;
        chk("p0_waveform_mismatches", mism, 0);
        chk("p0_busy_cycles", busy_count(base, 20), 10);

        // prescale change mid-frame applies to the next frame only
        prescale = 16'd2;
        Data_Valid = 1'b1; P_Data = 8'h0F;
        @(negedge clk);
        P_Data = 8'hF0;
        @(negedge clk);
        Data_Valid = 1'b0;
        base = cyc;
        repeat (2) @(negedge clk);
        prescale = 16'd3;
        repeat (60) @(negedge clk);
        chk("pc_f1_bits_high", ones_count(base + 2, 8), 8);
        chk("pc_f1_bit7", log_tx[base + 17], 0);
        chk("pc_f1_stop", log_tx[base + 18], 1);
        chk("pc_f1_stop_end", log_tx[base + 19], 1);
        chk("pc_f2_start", log_tx[base + 20], 0);
        chk("pc_f2_start_end", log_tx[base + 22], 0);
        chk("pc_f2_bit3", log_tx[base + 34], 0);
        chk("pc_f2_bit4", log_tx[base + 35], 1);
        chk("pc_f2_busy_last", log_busy[base + 49], 1);
        chk("pc_f2_busy_done", log_busy[base + 50], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
